// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full adder reused over N clocks, with the carry held in a register.
// somador1bit is the single-bit stage that the serial controller drives.

module somador1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module somador_serial #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout
);
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StSoma, StFim} estado_t;

    estado_t         estado_q, estado_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;
    logic [N-1:0]    s_sh_q, s_sh_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic            fa_s, fa_cout;

    somador1bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        estado_d = estado_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        s_sh_d   = s_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;
        unique case (estado_q)
            StIdle: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    estado_d = StSoma;
                end
            end
            StSoma: begin
                s_sh_d  = {fa_s, s_sh_q[N-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                // Last bit: publish the assembled sum including this cycle's bit.
                if (cnt_q == CntW'(N - 1)) begin
                    s_d      = {fa_s, s_sh_q[N-1:1]};
                    cout_d   = fa_cout;
                    estado_d = StFim;
                end
            end
            StFim:   estado_d = StIdle;
            default: estado_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            s_sh_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            s_sh_q   <= s_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (estado_q != StIdle);
    assign done = (estado_q == StFim);
    assign s    = s_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial: 8-bit directed cases plus an exhaustive 4-bit sweep.

module tb_somador_serial;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, s4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    somador_serial #(.N(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .cout  (cout8)
    );

    somador_serial #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .s     (s4),
        .cout  (cout4)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one 8-bit add, then count edges after the accepting edge until done.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] exp_s, input logic exp_c);
        int n;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 16'(n), 16'd8);
        check({tag, "_s"}, 16'(s8), 16'(exp_s));
        check({tag, "_cout"}, 16'(cout8), 16'(exp_c));
        tick();
        check({tag, "_done_pulse"}, 16'(done8), 16'd0);
        check({tag, "_idle"}, 16'(busy8), 16'd0);
    endtask

    initial begin
        int         n;
        int         ndone;
        logic [7:0] s_seen;
        logic [4:0] exp5;

        rst = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        tick();
        tick();
        check("rst_busy", 16'(busy8), 16'd0);
        check("rst_done", 16'(done8), 16'd0);
        check("rst_s", 16'(s8), 16'd0);
        check("rst_cout", 16'(cout8), 16'd0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_no_start", 16'(busy8), 16'd0);

        op8("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        op8("add_a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

        // start and operand changes while busy must be ignored
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h00;
        ndone = 0;
        s_seen = '0;
        for (int i = 0; i < 14; i++) begin
            if (done8) begin
                ndone++;
                s_seen = s8;
            end
            tick();
        end
        check("busy_one_done", 16'(ndone), 16'd1);
        check("busy_result", 16'(s_seen), 16'h46);
        check("busy_no_second_op", 16'(busy8), 16'd0);

        // reset in the middle of an operation
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("midrst_busy", 16'(busy8), 16'd0);
        check("midrst_done", 16'(done8), 16'd0);
        check("midrst_s", 16'(s8), 16'd0);
        check("midrst_cout", 16'(cout8), 16'd0);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) ndone++;
            tick();
        end
        check("midrst_no_done", 16'(ndone), 16'd0);
        op8("after_rst", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0);

        // exhaustive N=4 at the maximum issue rate
        for (int i = 0; i < 512; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1'b1;
            exp5 = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            tick();
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 12) begin
                tick();
                n++;
            end
            if (n != 4) check("n4_latency", 16'(n), 16'd4);
            check("n4_sum", 16'({cout4, s4}), 16'(exp5));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
